// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle sequencer: saturating target from inc/dec pulses, applied duty ramps 1 % per step.
// Each step waits RAMP_TICKS cycles and is then committed on the next PWM period boundary.
module pwm_duty_ramp_ctrl #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned PWM_FREQ       = 50,
  parameter int unsigned STEP_PCT       = 10,
  parameter int unsigned RAMP_TICKS     = 50_000,
  parameter int unsigned DUTY_RESET_PCT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_req,
  input  logic        dec_req,
  input  logic        period_end,
  output logic [6:0]  target_pct,
  output logic [6:0]  duty_pct,
  output logic [31:0] duty_cmp,
  output logic        update_stb,
  output logic        busy,
  output logic        at_max,
  output logic        at_min
);

  localparam int unsigned PERIOD_COUNTS = CLK_FREQ / PWM_FREQ;
  localparam int unsigned UNIT          = PERIOD_COUNTS / 100;
  // Counter only ever holds RAMP_TICKS-1 down to 0.
  localparam int unsigned TW            = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [TW-1:0] TICK_RELOAD = TW'(RAMP_TICKS - 1);
  localparam logic [7:0]    STEP8       = 8'(STEP_PCT);
  localparam logic [6:0]    STEP7       = 7'(STEP_PCT);
  localparam logic [7:0]    MAX8        = 8'd100;
  localparam logic [6:0]    RST_PCT     = 7'(DUTY_RESET_PCT);
  localparam logic [31:0]   UNIT_W      = 32'(UNIT);
  localparam logic [31:0]   RST_CMP     = 32'(DUTY_RESET_PCT * UNIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [6:0]   r_target;
  logic [6:0]   r_duty;
  logic [31:0]  r_cmp;
  logic         r_stb;

  logic [7:0]   w_tgt_up;
  logic [6:0]   w_tgt_inc;
  logic [6:0]   w_tgt_dec;
  logic [6:0]   w_duty_step;
  logic [6:0]   w_duty_nxt;
  logic         w_commit;

  // 8-bit sum so the saturation compare sees values above 100 without wrapping.
  assign w_tgt_up  = {1'b0, r_target} + STEP8;
  assign w_tgt_inc = (w_tgt_up > MAX8) ? 7'd100 : w_tgt_up[6:0];
  assign w_tgt_dec = (r_target < STEP7) ? 7'd0 : (r_target - STEP7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target <= RST_PCT;
    end else if (inc_req && !dec_req) begin
      r_target <= w_tgt_inc;
    end else if (dec_req && !inc_req) begin
      r_target <= w_tgt_dec;
    end
  end

  // Direction is taken from the live target at commit time.
  assign w_duty_step = (r_target > r_duty) ? (r_duty + 7'd1) : (r_duty - 7'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_duty_nxt  = r_duty;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_duty != r_target) begin
          w_state_nxt = S_RAMP;
          w_tick_nxt  = TICK_RELOAD;
        end
      end
      S_RAMP: begin
        if (r_tick == '0) begin
          w_state_nxt = S_ARMED;
        end else begin
          w_tick_nxt = r_tick - TW'(1);
        end
      end
      S_ARMED: begin
        if (period_end) begin
          if (r_duty != r_target) begin
            w_commit   = 1'b1;
            w_duty_nxt = w_duty_step;
            if (w_duty_step != r_target) begin
              w_state_nxt = S_RAMP;
              w_tick_nxt  = TICK_RELOAD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_duty  <= RST_PCT;
      r_cmp   <= RST_CMP;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_duty  <= w_duty_nxt;
      r_cmp   <= 32'(w_duty_nxt) * UNIT_W;
      r_stb   <= w_commit;
    end
  end

  assign target_pct = r_target;
  assign duty_pct   = r_duty;
  assign duty_cmp   = r_cmp;
  assign update_stb = r_stb;
  assign busy       = (r_state != S_IDLE) || (r_duty != r_target);
  assign at_max     = (r_target == 7'd100);
  assign at_min     = (r_target == 7'd0);

endmodule
